// File: rtl/deser_shift_in32_if.sv
// Serial-in / parallel-out bundle for deser_shift_in32.
// master = bit source + word consumer, slave = the deserializer.
interface deser_shift_in32_if #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
);
  logic             clr;
  logic             msb_first;
  logic             sin;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_cnt;

  modport master (
    output clr, msb_first, sin, sin_valid, dout_ready,
    input  sin_ready, dout, dout_valid, bit_cnt
  );

  modport slave (
    input  clr, msb_first, sin, sin_valid, dout_ready,
    output sin_ready, dout, dout_valid, bit_cnt
  );
endinterface

// File: rtl/deser_shift_in32.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words (LSB- or MSB-first)
// and hands them to a one-deep holding register with a valid/ready port.
module deser_shift_in32 #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  deser_shift_in32_if.slave bus
);

  typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_mode, w_mode_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;

  logic             w_accept;
  logic             w_msb;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;
  logic             w_can_load;

  // Bit order is latched on the first bit so a mid-word toggle is ignored.
  assign w_msb      = (r_cnt == '0) ? bus.msb_first : r_mode;
  assign w_shifted  = w_msb ? {r_sreg[WIDTH-2:0], bus.sin}
                            : {bus.sin, r_sreg[WIDTH-1:1]};
  assign w_accept   = bus.sin_valid && (r_state == COLLECT) && !bus.clr;
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_can_load = !r_dout_valid || bus.dout_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_sreg_nxt       = r_sreg;
    w_cnt_nxt        = r_cnt;
    w_mode_nxt       = r_mode;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid;

    // Drain first; a word loading this edge overrides it below.
    if (r_dout_valid && bus.dout_ready)
      w_dout_valid_nxt = 1'b0;

    if (bus.clr) begin
      w_sreg_nxt  = '0;
      w_cnt_nxt   = '0;
      w_state_nxt = COLLECT;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            w_sreg_nxt = w_shifted;
            w_cnt_nxt  = r_cnt + 1'b1;
            if (r_cnt == '0)
              w_mode_nxt = bus.msb_first;
            if (w_last) begin
              if (w_can_load) begin
                w_dout_nxt       = w_shifted;
                w_dout_valid_nxt = 1'b1;
                w_cnt_nxt        = '0;
              end else begin
                w_cnt_nxt   = CW'(WIDTH);
                w_state_nxt = FULL;
              end
            end
          end
        end
        FULL: begin
          if (bus.dout_ready) begin
            w_dout_nxt       = r_sreg;
            w_dout_valid_nxt = 1'b1;
            w_cnt_nxt        = '0;
            w_state_nxt      = COLLECT;
          end
        end
        default: w_state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= COLLECT;
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_mode       <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mode       <= w_mode_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
    end
  end

  assign bus.sin_ready  = (r_state == COLLECT);
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.bit_cnt    = r_cnt;

endmodule

// File: tb/tb_deser_shift_in32.sv
// Directed self-checking bench for deser_shift_in32.
module tb_deser_shift_in32;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   vcnt = 0;

  always #5 clk = ~clk;

  deser_shift_in32_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  deser_shift_in32 #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Counts cycles with dout_valid high, sampled away from the active edge.
  always @(negedge clk) if (reset_n && bus.dout_valid === 1'b1) vcnt++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    int t = 0;
    bus.sin = b;
    bus.sin_valid = 1'b1;
    while (bus.sin_ready !== 1'b1 && t < 100) begin tick(); t++; end
    if (t >= 100) begin
      checks++; failures++;
      $display("FAIL send_bit_timeout sin_ready=%b expected 1", bus.sin_ready);
    end
    tick();
    bus.sin_valid = 1'b0;
    bus.sin = 1'bx;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic msb, input int nbits, input bit gaps);
    for (int i = 0; i < nbits; i++) begin
      bus.msb_first = msb;
      send_bit(msb ? w[WIDTH-1-i] : w[i]);
      if (gaps) begin
        int g = $urandom_range(0, 5);
        for (int k = 0; k < g; k++) tick();
      end
    end
  endtask

  task automatic test_reset();
    send_word(32'hFFFF_FFFF, 1'b0, 32, 1'b0);
    send_word(32'h0000_001F, 1'b0, 5, 1'b0);
    checks++; if (bus.bit_cnt !== CW'(5)) begin failures++; $display("FAIL pre_reset_cnt got %0d expected 5", bus.bit_cnt); end
    checks++; if (bus.dout !== 32'hFFFF_FFFF || bus.dout_valid !== 1'b1) begin failures++; $display("FAIL pre_reset_dout got %h/%b expected ffffffff/1", bus.dout, bus.dout_valid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.dout !== '0) begin failures++; $display("FAIL reset_dout got %h expected 0", bus.dout); end
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got %b expected 0", bus.dout_valid); end
    checks++; if (bus.bit_cnt !== '0) begin failures++; $display("FAIL reset_bit_cnt got %0d expected 0", bus.bit_cnt); end
    @(negedge clk); reset_n = 1'b1;
    tick();
    checks++; if (bus.sin_ready !== 1'b1) begin failures++; $display("FAIL reset_sin_ready got %b expected 1", bus.sin_ready); end
  endtask

  task automatic test_lsb();
    bus.dout_ready = 1'b1;
    send_word(32'hA5A5_0F0F, 1'b0, 31, 1'b0);
    checks++; if (bus.dout_valid !== 1'b0 || bus.bit_cnt !== CW'(31)) begin failures++; $display("FAIL lsb_bit31 got dv=%b cnt=%0d expected 0/31", bus.dout_valid, bus.bit_cnt); end
    bus.sin = 1'b1; bus.sin_valid = 1'b1; tick(); bus.sin_valid = 1'b0;
    checks++; if (bus.dout !== 32'hA5A5_0F0F || bus.dout_valid !== 1'b1) begin failures++; $display("FAIL lsb_word got %h/%b expected a5a50f0f/1", bus.dout, bus.dout_valid); end
    checks++; if (bus.bit_cnt !== '0) begin failures++; $display("FAIL lsb_cnt got %0d expected 0", bus.bit_cnt); end
    tick();
    checks++; if (bus.dout_valid !== 1'b0 || bus.dout !== 32'hA5A5_0F0F) begin failures++; $display("FAIL lsb_drain got %h/%b expected a5a50f0f/0", bus.dout, bus.dout_valid); end
  endtask

  task automatic test_msb_toggle();
    logic [WIDTH-1:0] w = 32'h1234_5678;
    bus.dout_ready = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      bus.msb_first = (i < 5);
      send_bit(w[WIDTH-1-i]);
    end
    checks++; if (bus.dout !== 32'h1234_5678 || bus.dout_valid !== 1'b1) begin failures++; $display("FAIL msb_word got %h/%b expected 12345678/1", bus.dout, bus.dout_valid); end
    bus.msb_first = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.dout_ready = 1'b0;
    send_word(32'h0000_0001, 1'b0, 32, 1'b0);
    send_word(32'hFFFF_0000, 1'b0, 32, 1'b0);
    checks++; if (bus.sin_ready !== 1'b0 || bus.bit_cnt !== CW'(32)) begin failures++; $display("FAIL bp_full got rdy=%b cnt=%0d expected 0/32", bus.sin_ready, bus.bit_cnt); end
    checks++; if (bus.dout !== 32'h0000_0001 || bus.dout_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got %h/%b expected 00000001/1", bus.dout, bus.dout_valid); end
    bus.sin = 1'b1; bus.sin_valid = 1'b1; tick(); bus.sin_valid = 1'b0;
    checks++; if (bus.bit_cnt !== CW'(32)) begin failures++; $display("FAIL bp_no_accept got %0d expected 32", bus.bit_cnt); end
    bus.dout_ready = 1'b1;
    tick();
    checks++; if (bus.dout !== 32'hFFFF_0000 || bus.dout_valid !== 1'b1 || bus.sin_ready !== 1'b1) begin failures++; $display("FAIL bp_transfer got %h/%b rdy=%b expected ffff0000/1/1", bus.dout, bus.dout_valid, bus.sin_ready); end
    checks++; if (bus.bit_cnt !== '0) begin failures++; $display("FAIL bp_cnt got %0d expected 0", bus.bit_cnt); end
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got %b expected 0", bus.dout_valid); end
  endtask

  task automatic test_back_to_back();
    bus.dout_ready = 1'b0;
    send_word(32'h8000_0003, 1'b0, 32, 1'b0);
    send_word(32'h0F0F_1234, 1'b1, 31, 1'b0);
    bus.dout_ready = 1'b1;
    send_bit(1'b0);
    checks++; if (bus.dout !== 32'h0F0F_1234 || bus.dout_valid !== 1'b1 || bus.sin_ready !== 1'b1) begin failures++; $display("FAIL b2b_replace got %h/%b rdy=%b expected 0f0f1234/1/1", bus.dout, bus.dout_valid, bus.sin_ready); end
    tick();
    checks++; if (bus.dout_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got %b expected 0", bus.dout_valid); end
  endtask

  task automatic test_gaps();
    bus.dout_ready = 1'b1;
    vcnt = 0;
    send_word(32'hA5A5_0F0F, 1'b0, 32, 1'b1);
    tick(); tick();
    send_word(32'h1234_5678, 1'b1, 32, 1'b1);
    checks++; if (bus.dout !== 32'h1234_5678) begin failures++; $display("FAIL gaps_word got %h expected 12345678", bus.dout); end
    tick(); tick();
    checks++; if (vcnt != 2) begin failures++; $display("FAIL gaps_pulses got %0d expected 2", vcnt); end
  endtask

  task automatic test_clr();
    bus.dout_ready = 1'b1;
    send_word(32'hFFFF_FFFF, 1'b0, 10, 1'b0);
    bus.clr = 1'b1; bus.sin = 1'b1; bus.sin_valid = 1'b1; tick();
    bus.clr = 1'b0; bus.sin_valid = 1'b0;
    checks++; if (bus.bit_cnt !== '0) begin failures++; $display("FAIL clr_cnt got %0d expected 0", bus.bit_cnt); end
    send_word(32'hCAFE_BABE, 1'b0, 32, 1'b0);
    checks++; if (bus.dout !== 32'hCAFE_BABE || bus.dout_valid !== 1'b1) begin failures++; $display("FAIL clr_word got %h/%b expected cafebabe/1", bus.dout, bus.dout_valid); end
    tick();
    bus.dout_ready = 1'b0;
    send_word(32'h1111_1111, 1'b0, 32, 1'b0);
    send_word(32'h2222_2222, 1'b0, 32, 1'b0);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    checks++; if (bus.bit_cnt !== '0 || bus.sin_ready !== 1'b1) begin failures++; $display("FAIL clr_full got cnt=%0d rdy=%b expected 0/1", bus.bit_cnt, bus.sin_ready); end
    checks++; if (bus.dout !== 32'h1111_1111 || bus.dout_valid !== 1'b1) begin failures++; $display("FAIL clr_hold got %h/%b expected 11111111/1", bus.dout, bus.dout_valid); end
    bus.dout_ready = 1'b1;
    tick(); tick();
    checks++; if (bus.dout !== 32'h1111_1111 || bus.dout_valid !== 1'b0) begin failures++; $display("FAIL clr_dropped got %h/%b expected 11111111/0", bus.dout, bus.dout_valid); end
  endtask

  initial begin
    bus.clr = 1'b0; bus.msb_first = 1'b0; bus.sin = 1'b0;
    bus.sin_valid = 1'b0; bus.dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    tick();
    test_reset();
    test_lsb();
    test_msb_toggle();
    test_backpressure();
    test_back_to_back();
    test_gaps();
    test_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
